prog_launch_seq: RTL

Host-side initiator for the processor's Start/Ack run handshake. It sequences NUM_PROGS programs back-to-back. For each program it pulses Start, waits for the processor's Ack, and records how many cycles the program ran. It sits beside the processor top level in the test harness and in the board wrapper. It drives the processor's Start input and consumes its Ack output, with a timeout so a hung program cannot stall the sequence.

---
 rtl/prog_launch_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/prog_launch_seq.sv
// Host-side Start/Ack launcher: runs NUM_PROGS programs back-to-back with a per-program timeout.
// Optional per-program cycle log is enabled by defining PROG_CYCLE_LOG_EN.
module prog_launch_seq #(
    parameter int unsigned NUM_PROGS    = 3,
    parameter int unsigned PIDX_W       = 2,
    parameter int unsigned START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic              Ack,
`ifdef PROG_CYCLE_LOG_EN
    input  logic [PIDX_W-1:0] LogIdx,
    output logic [15:0]       LogData,
`endif
    output logic              Start,
    output logic [PIDX_W-1:0] ProgIdx,
    output logic [15:0]       CycleCount,
    output logic              Busy,
    output logic              Done,
    output logic              TimedOut
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ASSERT = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] NEXT   = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    localparam int unsigned       SC_W     = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(START_CYCLES - 1);
    localparam logic [PIDX_W-1:0] LAST_IDX = PIDX_W'(NUM_PROGS - 1);
    localparam logic [15:0]       RUN_LAST = TIMEOUT - 16'd1;

    logic [2:0]        state_q, state_d;
    logic              start_q, start_d;
    logic [PIDX_W-1:0] idx_q, idx_d;
    logic [15:0]       cycle_q, cycle_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic [15:0]       run_q, run_d;
    logic [SC_W-1:0]   scnt_q, scnt_d;
    logic              armed_q, armed_d;
    logic              go_accept, ack_accept, launch;

    assign go_accept  = ((state_q == IDLE) || (state_q == FINISH)) && Go;
    // An Ack only counts once a low level has been seen for this program.
    assign ack_accept = (state_q == RUN) && armed_q && Ack;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        idx_d   = idx_q;
        cycle_d = cycle_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        run_d   = run_q;
        scnt_d  = scnt_q;
        armed_d = armed_q;
        launch  = 1'b0;

        if (((state_q == ASSERT) || (state_q == RUN)) && !Ack) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE, FINISH: begin
                if (go_accept) begin
                    done_d = 1'b0;
                    tmo_d  = 1'b0;
                    idx_d  = '0;
                    launch = 1'b1;
                end
            end
            ASSERT: begin
                if (scnt_q == SC_LAST) begin
                    state_d = RUN;
                    start_d = 1'b0;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            RUN: begin
                if (ack_accept) begin
                    cycle_d = run_q;
                    state_d = NEXT;
                end else if (run_q == RUN_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    run_d = run_q + 16'd1;
                end
            end
            NEXT: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    launch = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d = ASSERT;
            start_d = 1'b1;
            scnt_d  = '0;
            run_d   = '0;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            idx_q   <= '0;
            cycle_q <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            run_q   <= '0;
            scnt_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            idx_q   <= idx_d;
            cycle_q <= cycle_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            run_q   <= run_d;
            scnt_q  <= scnt_d;
            armed_q <= armed_d;
        end
    end

    assign Start      = start_q;
    assign ProgIdx    = idx_q;
    assign CycleCount = cycle_q;
    assign Done       = done_q;
    assign TimedOut   = tmo_q;
    assign Busy       = (state_q == ASSERT) || (state_q == RUN) || (state_q == NEXT);

`ifdef PROG_CYCLE_LOG_EN
    localparam logic [PIDX_W:0] NUM_PROGS_EXT = (PIDX_W + 1)'(NUM_PROGS);

    logic [15:0] log_q [NUM_PROGS];

    always_ff @(posedge Clk) begin
        if (Reset || go_accept) begin
            for (int i = 0; i < int'(NUM_PROGS); i++) begin
                log_q[i] <= '0;
            end
        end else if (ack_accept) begin
            log_q[idx_q] <= run_q;
        end
    end

    // Indices past the last program read as zero.
    always_comb begin
        LogData = '0;
        if ({1'b0, LogIdx} < NUM_PROGS_EXT) begin
            LogData = log_q[LogIdx];
        end
    end
`endif

endmodule
